// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling ratio.
// The Receiver imports this package as well.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start bit, DBIT data bits LSB-first, optional parity bit
// and stop bit(s), paced by the shared 16x oversampled baud tick.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx_ready,
   output logic            tx_done_tick,
   output logic            tx
);

   localparam logic [4:0] S_LAST    = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

   logic [2:0]      state_reg, state_next;
   logic [4:0]      s_reg, s_next;
   logic [2:0]      n_reg, n_next;
   logic [DBIT-1:0] shift_reg, shift_next;
   logic            par_reg, par_next;
   logic            tx_reg, tx_next;
   logic            done_reg, done_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         tx_reg    <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         tx_reg    <= tx_next;
         done_reg  <= done_next;
      end
   end

   // A tick arriving in the same cycle as acceptance is deliberately not counted.
   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      shift_next = shift_reg;
      par_next   = par_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (tx_start) begin
               shift_next = din;
               par_next   = (^din) ^ 1'(PARITY_ODD);
               s_next     = '0;
               state_next = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_reg == S_LAST) begin
                  s_next     = '0;
                  n_next     = '0;
                  state_next = DATA;
               end else begin
                  s_next = s_reg + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_reg == S_LAST) begin
                  s_next     = '0;
                  shift_next = shift_reg >> 1;
                  if (n_reg == N_LAST) begin
                     state_next = (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     n_next = n_reg + 3'd1;
                  end
               end else begin
                  s_next = s_reg + 5'd1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s_reg == S_LAST) begin
                  s_next     = '0;
                  state_next = STOP;
               end else begin
                  s_next = s_reg + 5'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_reg == STOP_LAST) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  s_next = s_reg + 5'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The line is derived from next-state values so it switches on the same edge as the FSM.
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         PARITY:  tx_next = par_next;
         default: tx_next = 1'b1;
      endcase
   end

   assign tx_ready     = (state_reg == IDLE);
   assign tx_done_tick = done_reg;
   assign tx           = tx_reg;

endmodule
